// File: rtl/timer_pwm_capture.sv
// timer_pwm_capture: measures period and active time of an external PWM signal.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   i_enable        - 0 forces IDLE and clears the measurement counter/divider
//   i_pin, i_pol    - asynchronous PWM input and its active level
//   i_continuous    - 1 re-arms after each result, 0 captures a single result
//   i_prescaler     - tick divider (0 and 1 both mean a tick every clk)
//   i_ack           - pulse clearing o_valid / o_overrun
//   o_period        - ticks from one active edge to the next (both ends inclusive)
//   o_active        - ticks spent at the active level within that period
//   o_valid, o_overrun, o_timeout - sticky status flags
//   o_state         - FSM state (IDLE=0, ARM=1, ACTIVE=2, INACTIVE=3)
module timer_pwm_capture #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_pin,
  input  logic             i_pol,
  input  logic             i_continuous,
  input  logic [31:0]      i_prescaler,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_active,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_timeout,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    ACTIVE   = 2'd2,
    INACTIVE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic [31:0]      r_div;
  logic [WIDTH-1:0] r_cnt, r_act_len;

  logic             w_tick, w_act_edge, w_inact_edge, w_sat, w_write;
  logic [WIDTH-1:0] w_cnt_inc, w_cnt_restart;
  logic [WIDTH-1:0] w_cnt_nxt, w_act_len_nxt, w_period_nxt, w_active_nxt;
  logic             w_valid_nxt, w_overrun_nxt, w_timeout_nxt;

  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_act_edge   = (r_s2 == i_pol) && (r_s3 != i_pol);
  assign w_inact_edge = (r_s2 != i_pol) && (r_s3 == i_pol);

  // Free-running tick divider; tick on terminal count
  assign w_tick = (i_prescaler <= 32'd1) || (r_div == (i_prescaler - 32'd1));

  always_ff @(posedge clk) begin
    if (rst || !i_enable) begin
      r_div <= 32'd0;
    end else if (w_tick) begin
      r_div <= 32'd0;
    end else begin
      r_div <= r_div + 32'd1;
    end
  end

  assign w_cnt_inc     = r_cnt + WIDTH'(w_tick);
  assign w_cnt_restart = WIDTH'(w_tick);
  // Saturation only matters while a measurement is running
  assign w_sat   = ((r_state == ACTIVE) || (r_state == INACTIVE)) && (r_cnt == '1) && w_tick;
  assign w_write = i_enable && (r_state == INACTIVE) && w_act_edge && !w_sat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (!o_valid || i_continuous) w_state_nxt = ARM;
        ARM:      if (w_act_edge) w_state_nxt = ACTIVE;
        ACTIVE: begin
          if (w_sat)             w_state_nxt = ARM;
          else if (w_inact_edge) w_state_nxt = INACTIVE;
        end
        INACTIVE: begin
          if (w_sat)           w_state_nxt = ARM;
          else if (w_act_edge) w_state_nxt = i_continuous ? ACTIVE : IDLE;
        end
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and flag next values
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_act_len_nxt = r_act_len;
    w_period_nxt  = o_period;
    w_active_nxt  = o_active;
    w_valid_nxt   = o_valid;
    w_overrun_nxt = o_overrun;
    w_timeout_nxt = o_timeout;

    if (!i_enable) begin
      w_cnt_nxt     = '0;
      w_act_len_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt = '0;
          if (w_state_nxt == ARM) w_timeout_nxt = 1'b0;
        end
        ARM: begin
          if (w_act_edge) w_cnt_nxt = w_cnt_restart;
        end
        ACTIVE: begin
          if (w_sat) begin
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_inact_edge) w_act_len_nxt = w_cnt_inc;
          end
        end
        INACTIVE: begin
          if (w_sat) begin
            w_timeout_nxt = 1'b1;
            w_cnt_nxt     = '0;
          end else if (w_act_edge) begin
            w_period_nxt = w_cnt_inc;
            w_active_nxt = r_act_len;
            w_cnt_nxt    = w_cnt_restart;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_cnt_nxt = '0;
      endcase
    end

    // A result landing together with i_ack stays valid; the ack consumes the old one
    if (w_write) begin
      w_valid_nxt = 1'b1;
      if (i_ack)        w_overrun_nxt = 1'b0;
      else if (o_valid) w_overrun_nxt = 1'b1;
    end else if (i_ack) begin
      w_valid_nxt   = 1'b0;
      w_overrun_nxt = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_act_len <= '0;
      o_period  <= '0;
      o_active  <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_act_len <= w_act_len_nxt;
      o_period  <= w_period_nxt;
      o_active  <= w_active_nxt;
      o_valid   <= w_valid_nxt;
      o_overrun <= w_overrun_nxt;
      o_timeout <= w_timeout_nxt;
    end
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_timer_pwm_capture.sv
// Testbench for timer_pwm_capture: random and directed PWM waveforms, expected
// results computed from tick arithmetic and checked by a scoreboard monitor.
module tb_timer_pwm_capture;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_enable, i_pin, i_pol, i_continuous, i_ack;
  logic [31:0]  i_prescaler;
  logic [W-1:0] o_period, o_active;
  logic         o_valid, o_overrun, o_timeout;
  logic [1:0]   o_state;

  timer_pwm_capture #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_pin(i_pin), .i_pol(i_pol),
    .i_continuous(i_continuous), .i_prescaler(i_prescaler), .i_ack(i_ack),
    .o_period(o_period), .o_active(o_active), .o_valid(o_valid),
    .o_overrun(o_overrun), .o_timeout(o_timeout), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Edge index: value of cyc right after a rising edge
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int period;
    int active;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference model: ticks land on edges m with (m-k0) mod P == P-1
  int k0, pp;
  bit m_cont, m_have_a, m_have_i, m_done;
  int m_a, m_i;
  int last_period, last_active;

  function automatic int ticks_upto(input int x);
    return (x - k0 + 1) / pp;
  endfunction

  function automatic int ticks(input int a, input int b);
    return ticks_upto(b) - ticks_upto(a - 1);
  endfunction

  // Pin changed now is acted on three rising edges later
  task automatic note_active();
    int   e;
    res_t r;
    e = cyc + 3;
    if (!m_done) begin
      if (m_have_i) begin
        r.period = ticks(m_a, e);
        r.active = ticks(m_a, m_i);
        exp_q.push_back(r);
        last_period = r.period;
        last_active = r.active;
        if (!m_cont) m_done = 1'b1;
      end
      m_a = e;
      m_have_a = 1'b1;
      m_have_i = 1'b0;
    end
  endtask

  task automatic note_inactive();
    if (!m_done && m_have_a) begin
      m_i = cyc + 3;
      m_have_i = 1'b1;
    end
  endtask

  task automatic drive_pin(input bit act);
    i_pin = act ? i_pol : ~i_pol;
    if (act) note_active();
    else     note_inactive();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic period(input int a, input int b);
    drive_pin(1'b1);
    idle(a);
    drive_pin(1'b0);
    idle(b);
  endtask

  task automatic start_run(input int p, input bit pol, input bit cont);
    @(negedge clk);
    i_enable     = 1'b0;
    i_pol        = pol;
    i_prescaler  = 32'(p);
    i_continuous = cont;
    i_pin        = ~pol;
    idle(4);
    k0       = cyc + 1;
    pp       = (p <= 1) ? 1 : p;
    m_cont   = cont;
    m_have_a = 1'b0;
    m_have_i = 1'b0;
    m_done   = 1'b0;
    i_enable = 1'b1;
    idle(3);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 0);
  endtask

  // Monitor: a result is presented when o_valid rises or stays high after an ack
  bit   mon_en = 1'b0;
  bit   auto_ack = 1'b0;
  bit   acked = 1'b0;
  logic prev_v = 1'b0;
  bit   new_res;
  res_t mon_r;

  always @(negedge clk) begin
    new_res = (o_valid === 1'b1) && (!prev_v || acked);
    if (auto_ack) i_ack = 1'b0;
    acked = 1'b0;
    if (mon_en && new_res) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got period %0d active %0d, required no result",
                 o_period, o_active);
      end else begin
        mon_r = exp_q.pop_front();
        chk("period", 32'(o_period), 32'(mon_r.period));
        chk("active", 32'(o_active), 32'(mon_r.active));
      end
      if (auto_ack) begin
        i_ack = 1'b1;
        acked = 1'b1;
      end
    end
    prev_v = o_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  int p_r, a_r, b_r;
  bit pol_r;
  int sv_period, sv_active;

  initial begin
    rst = 1'b1; i_enable = 1'b1; i_pin = 1'b1; i_pol = 1'b1;
    i_continuous = 1'b1; i_ack = 1'b1; i_prescaler = 32'd1;
    idle(3);
    // Reset dominates enable, ack and pin activity
    chk("rst_state",   32'(o_state),   0);
    chk("rst_valid",   32'(o_valid),   0);
    chk("rst_period",  32'(o_period),  0);
    chk("rst_active",  32'(o_active),  0);
    chk("rst_overrun", 32'(o_overrun), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    rst = 1'b0; i_enable = 1'b0; i_ack = 1'b0; i_pin = 1'b0;

    mon_en = 1'b1; auto_ack = 1'b1;

    // Basic 30/70 waveform
    start_run(1, 1'b1, 1'b1);
    repeat (3) period(30, 70);
    drive_pin(1'b1); idle(5); drain();

    // Prescaled waveform
    start_run(4, 1'b1, 1'b1);
    repeat (2) period(120, 280);
    drive_pin(1'b1); idle(5); drain();

    // Active-low polarity
    start_run(1, 1'b0, 1'b1);
    repeat (2) period(25, 75);
    drive_pin(1'b1); idle(5); drain();

    // Random prescaler, polarity and duty
    for (int r = 0; r < 6; r++) begin
      p_r   = $urandom_range(0, 3);
      pol_r = 1'($urandom_range(0, 1));
      start_run(p_r, pol_r, 1'b1);
      for (int k = 0; k < 3; k++) begin
        a_r = $urandom_range(4, 40);
        b_r = $urandom_range(4, 40);
        period(a_r, b_r);
      end
      drive_pin(1'b1); idle(5); drive_pin(1'b0); idle(3); drain();
    end

    // Single-shot: exactly one result, then parked in IDLE
    auto_ack = 1'b0;
    @(negedge clk); i_ack = 1'b0;
    start_run(1, 1'b1, 1'b0);
    repeat (3) period(20, 30);
    drive_pin(1'b1); idle(5); drain();
    chk("single_state", 32'(o_state), 0);
    chk("single_valid", 32'(o_valid), 1);
    i_ack = 1'b1; @(negedge clk); i_ack = 1'b0;
    chk("single_ack_valid", 32'(o_valid), 0);

    // Overrun and ack coinciding with a result write
    mon_en = 1'b0;
    start_run(1, 1'b1, 1'b1);
    exp_q.delete();
    period(20, 30);
    drive_pin(1'b1); idle(20);
    drive_pin(1'b0); idle(30);
    drive_pin(1'b1); idle(5);
    chk("ovr_overrun", 32'(o_overrun), 1);
    chk("ovr_valid",   32'(o_valid),   1);
    chk("ovr_period",  32'(o_period),  32'(last_period));
    idle(15);
    drive_pin(1'b0); idle(30);
    drive_pin(1'b1);
    @(negedge clk);
    @(negedge clk); i_ack = 1'b1;
    @(negedge clk); i_ack = 1'b0;
    chk("ackwr_valid",  32'(o_valid),  1);
    chk("ackwr_period", 32'(o_period), 32'(last_period));
    chk("ackwr_active", 32'(o_active), 32'(last_active));
    idle(2);
    i_ack = 1'b1; @(negedge clk); i_ack = 1'b0;
    chk("ack_valid",   32'(o_valid),   0);
    chk("ack_overrun", 32'(o_overrun), 0);
    exp_q.delete();

    // Enable drop mid-ACTIVE: IDLE, results held, no new result
    mon_en = 1'b1; auto_ack = 1'b1;
    start_run(2, 1'b1, 1'b1);
    period(20, 30);
    drive_pin(1'b1); idle(10); drain();
    sv_period = last_period; sv_active = last_active;
    chk("en_pre_state", 32'(o_state), 2);
    i_enable = 1'b0; m_done = 1'b1;
    @(negedge clk);
    chk("en_off_state",  32'(o_state),  0);
    chk("en_off_period", 32'(o_period), 32'(sv_period));
    chk("en_off_active", 32'(o_active), 32'(sv_active));
    drive_pin(1'b0); idle(10);
    chk("en_off_valid", 32'(o_valid), 0);

    // Reset mid-ACTIVE discards everything
    start_run(1, 1'b1, 1'b1);
    period(20, 30);
    drive_pin(1'b1); idle(10); drain();
    chk("rst_pre_state", 32'(o_state), 2);
    rst = 1'b1; m_done = 1'b1;
    @(negedge clk);
    chk("rst_mid_state",  32'(o_state),  0);
    chk("rst_mid_period", 32'(o_period), 0);
    chk("rst_mid_valid",  32'(o_valid),  0);
    rst = 1'b0; i_enable = 1'b0;
    idle(3);

    // Timeout: pin stuck at active level after the first edge
    start_run(1, 1'b1, 1'b1);
    drive_pin(1'b1);
    idle(100);
    chk("to_early_flag",  32'(o_timeout), 0);
    chk("to_early_state", 32'(o_state),   2);
    idle(170);
    chk("to_flag",  32'(o_timeout), 1);
    chk("to_state", 32'(o_state),   1);
    chk("to_valid", 32'(o_valid),   0);
    i_enable = 1'b0; idle(2);
    chk("to_held_idle", 32'(o_timeout), 1);
    i_enable = 1'b1; idle(2);
    chk("to_rearm_flag",  32'(o_timeout), 0);
    chk("to_rearm_state", 32'(o_state),   1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
